// File: rtl/link_tx_sender_if.sv
// Link-side bundle for the NoC output sender: FIFO head/occupancy/pop plus
// the credit-controlled link toward the neighbouring router.
interface link_tx_sender_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
);
  logic [WIDTH-1:0]         head;
  logic [$clog2(DEPTH):0]   counter;
  logic                     pull;
  logic                     credit_i;
  logic                     tx;
  logic [WIDTH-1:0]         data_out;
  logic                     sending;
  logic                     pkt_done;

  // The sender pops the FIFO and drives the link.
  modport master (
    input  head, counter, credit_i,
    output pull, tx, data_out, sending, pkt_done
  );

  // FIFO / receiver side.
  modport slave (
    output head, counter, credit_i,
    input  pull, tx, data_out, sending, pkt_done
  );
endinterface

// File: rtl/link_tx_sender.sv
// Output-side FIFO reader for the Phoenix NoC router. Pops flits from the
// input buffer head and drives them onto the link through a single
// registered output stage with credit flow control. Packets are framed as
// header, size (payload count N), then N payload flits.
module link_tx_sender #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  link_tx_sender_if.master lnk
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SIZE,
    S_PAYLOAD
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] remaining_q, remaining_d;
  logic [WIDTH-1:0] data_q;
  logic             tx_q;
  logic             last_q, last_d;
  logic             pkt_done_q;
  logic [CW-1:0]    occupancy;
  logic             xfer;
  logic             can_load;
  logic             avail;
  logic             pull;

  assign occupancy = lnk.counter;
  assign xfer      = tx_q & lnk.credit_i;
  assign can_load  = ~tx_q | xfer;
  assign avail     = (occupancy != '0);
  // Every state loads the same way, so the pop strobe is state-independent.
  assign pull      = reset & avail & can_load;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state: framing advances only on a load
  always_comb begin
    state_d = state_q;
    if (pull) begin
      case (state_q)
        S_IDLE:    state_d = S_SIZE;
        S_SIZE:    state_d = (lnk.head == '0) ? S_IDLE : S_PAYLOAD;
        S_PAYLOAD: state_d = (remaining_q == WIDTH'(1)) ? S_IDLE : S_PAYLOAD;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Per-load framing outputs: payload count update and end-of-packet mark
  always_comb begin
    remaining_d = remaining_q;
    last_d      = 1'b0;
    case (state_q)
      S_SIZE: begin
        remaining_d = lnk.head;
        last_d      = (lnk.head == '0);
      end
      S_PAYLOAD: begin
        remaining_d = remaining_q - WIDTH'(1);
        last_d      = (remaining_q == WIDTH'(1));
      end
      default: begin
        remaining_d = remaining_q;
        last_d      = 1'b0;
      end
    endcase
  end

  // Output register: load on pull, release on transfer, otherwise hold
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_q        <= 1'b0;
      data_q      <= '0;
      last_q      <= 1'b0;
      remaining_q <= '0;
      pkt_done_q  <= 1'b0;
    end else begin
      pkt_done_q <= xfer & last_q;
      if (pull) begin
        data_q      <= lnk.head;
        tx_q        <= 1'b1;
        last_q      <= last_d;
        remaining_q <= remaining_d;
      end else if (xfer) begin
        tx_q <= 1'b0;
      end
    end
  end

  assign lnk.pull     = pull;
  assign lnk.tx       = tx_q;
  assign lnk.data_out = data_q;
  assign lnk.pkt_done = pkt_done_q;
  assign lnk.sending  = reset & ((state_q != S_IDLE) | tx_q);

endmodule

// File: tb/tb_link_tx_sender.sv
// Bench for link_tx_sender: a queue-based FIFO model feeds the head/counter
// inputs, a negedge monitor logs pulls, link transfers and pkt_done pulses,
// and each test compares those logs with the packet framing derived from
// the pushed flit stream.
module tb_link_tx_sender;
  localparam int W  = 16;
  localparam int D  = 16;
  localparam int CW = $clog2(D) + 1;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  link_tx_sender_if #(.WIDTH(W), .DEPTH(D)) bus ();
  link_tx_sender #(.WIDTH(W), .DEPTH(D)) dut (
    .clock (clock),
    .reset (reset),
    .lnk   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // FIFO model: pushed flits stay in push_q, rd_ptr marks the head.
  logic [W-1:0] push_q[$];
  int           rd_ptr = 0;
  logic         samp_pull = 1'b0;
  int           cyc = 0;

  // Monitor logs
  logic [W-1:0] rx_data[$];
  int           rx_cyc[$];
  int           pull_cyc[$];
  int           done_cyc[$];

  // Reference model results
  bit           exp_last[$];
  int           exp_done[$];

  // Sample the link mid-cycle; a logged xfer completes on the next edge
  always @(negedge clock) begin
    samp_pull = bus.pull;
    if (bus.pull === 1'b1) pull_cyc.push_back(cyc);
    if (bus.tx === 1'b1 && bus.credit_i === 1'b1) begin
      rx_data.push_back(bus.data_out);
      rx_cyc.push_back(cyc);
    end
    if (bus.pkt_done === 1'b1) done_cyc.push_back(cyc);
    cyc = cyc + 1;
  end

  // FIFO pops after the edge on which pull was high; reset empties it
  always @(posedge clock) begin
    #1;
    if (!reset) rd_ptr = push_q.size();
    else if (samp_pull) rd_ptr = rd_ptr + 1;
    bus.counter = CW'(push_q.size() - rd_ptr);
    bus.head    = (push_q.size() > rd_ptr) ? push_q[rd_ptr] : '0;
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic push(input logic [W-1:0] f);
    push_q.push_back(f);
  endtask

  // Wait until the FIFO is empty and the link idle, then let pkt_done land
  task automatic drain(input string name);
    int k = 0;
    while ((push_q.size() != rd_ptr || bus.tx !== 1'b0) && k < 400) begin
      tick();
      k++;
    end
    tick();
    tick();
    n_cmp++;
    if (k >= 400) begin
      n_err++;
      $display("FAIL %s drain_timeout: waited %0d cycles, required < 400", name, k);
    end
  endtask

  // Packet framing from the pushed stream: header, size N, N payloads
  task automatic build_model(input int pb);
    int p;
    int n;
    exp_last.delete();
    for (int i = pb; i < push_q.size(); i++) exp_last.push_back(1'b0);
    p = pb;
    while (p + 1 < push_q.size()) begin
      n = int'(push_q[p + 1]);
      if (p + 1 + n < push_q.size()) exp_last[p + 1 + n - pb] = 1'b1;
      p = p + 2 + n;
    end
  endtask

  // pkt_done is expected one cycle after each end-of-packet transfer
  task automatic build_done(input int rb);
    exp_done.delete();
    for (int i = 0; i < exp_last.size() && rb + i < rx_cyc.size(); i++)
      if (exp_last[i]) exp_done.push_back(rx_cyc[rb + i] + 1);
  endtask

  task automatic test_reset();
    int k = 0;
    reset = 1'b1;
    bus.credit_i = 1'b1;
    #1 reset = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (bus.tx !== 1'b0 || bus.pull !== 1'b0 || bus.sending !== 1'b0 ||
        bus.data_out !== '0 || bus.pkt_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: tx=%b pull=%b sending=%b data=%h done=%b, required all 0",
               bus.tx, bus.pull, bus.sending, bus.data_out, bus.pkt_done);
    end
    reset = 1'b1;
    tick();
    // Abandon a packet while a payload flit is on the link
    push(16'h0011); push(16'h0005);
    push(16'hA001); push(16'hA002); push(16'hA003); push(16'hA004); push(16'hA005);
    while (!(bus.tx === 1'b1 && bus.data_out === 16'hA002) && k < 50) begin
      tick();
      k++;
    end
    n_cmp++;
    if (k >= 50) begin
      n_err++;
      $display("FAIL reset_reach_payload: waited %0d cycles, required < 50", k);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (bus.tx !== 1'b0 || bus.pull !== 1'b0 || bus.sending !== 1'b0 || bus.data_out !== '0) begin
      n_err++;
      $display("FAIL reset_async: tx=%b pull=%b sending=%b data=%h, required all 0",
               bus.tx, bus.pull, bus.sending, bus.data_out);
    end
    tick();
    reset = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (bus.sending !== 1'b0 || bus.tx !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle_after: sending=%b tx=%b, required 0 0", bus.sending, bus.tx);
    end
  endtask

  task automatic test_stream();
    int pb = push_q.size();
    int rb = rx_data.size();
    int pcb = pull_cyc.size();
    int db = done_cyc.size();
    bus.credit_i = 1'b1;
    push(16'h0011); push(16'h0003); push(16'hA001); push(16'hA002); push(16'hA003);
    drain("stream");
    build_model(pb);
    build_done(rb);
    n_cmp++;
    if (pull_cyc.size() - pcb != 5 || pull_cyc[pcb + 4] - pull_cyc[pcb] != 4) begin
      n_err++;
      $display("FAIL stream_pull_run: pulls=%0d, required 5 consecutive", pull_cyc.size() - pcb);
    end
    n_cmp++;
    if (rx_data.size() - rb != 5) begin
      n_err++;
      $display("FAIL stream_rx_count: got %0d, required 5", rx_data.size() - rb);
    end
    for (int i = 0; i < 5 && rb + i < rx_data.size() && pcb + i < pull_cyc.size(); i++) begin
      n_cmp++;
      if (rx_data[rb + i] !== push_q[pb + i] || rx_cyc[rb + i] != pull_cyc[pcb + i] + 1) begin
        n_err++;
        $display("FAIL stream_flit%0d: got %h at cycle %0d, required %h at cycle %0d",
                 i, rx_data[rb + i], rx_cyc[rb + i], push_q[pb + i], pull_cyc[pcb + i] + 1);
      end
    end
    n_cmp++;
    if (done_cyc.size() - db != 1 || exp_done.size() != 1 || done_cyc[db] != exp_done[0]) begin
      n_err++;
      $display("FAIL stream_pkt_done: got %0d pulses, required 1 following the 0xA003 transfer",
               done_cyc.size() - db);
    end
  endtask

  task automatic test_backpressure();
    int pb = push_q.size();
    int rb = rx_data.size();
    int db = done_cyc.size();
    int held = 0;
    int k = 0;
    bus.credit_i = 1'b1;
    push(16'h0011); push(16'h0003); push(16'hA001); push(16'hA002); push(16'hA003);
    while ((push_q.size() != rd_ptr || bus.tx !== 1'b0) && k < 100) begin
      tick();
      k++;
      if (bus.tx === 1'b1 && bus.data_out === 16'hA001 && held < 3) begin
        bus.credit_i = 1'b0;
        held++;
        #1;
        n_cmp++;
        if (bus.pull !== 1'b0) begin
          n_err++;
          $display("FAIL bp_pull_stalled: pull=%b, required 0", bus.pull);
        end
      end else begin
        bus.credit_i = 1'b1;
      end
    end
    bus.credit_i = 1'b1;
    drain("backpressure");
    build_model(pb);
    build_done(rb);
    n_cmp++;
    if (held != 3) begin
      n_err++;
      $display("FAIL bp_hold: 0xA001 held %0d stalled cycles, required 3", held);
    end
    n_cmp++;
    if (rx_data.size() - rb != 5) begin
      n_err++;
      $display("FAIL bp_rx_count: got %0d, required 5", rx_data.size() - rb);
    end
    for (int i = 0; i < 5 && rb + i < rx_data.size(); i++) begin
      n_cmp++;
      if (rx_data[rb + i] !== push_q[pb + i]) begin
        n_err++;
        $display("FAIL bp_flit%0d: got %h, required %h", i, rx_data[rb + i], push_q[pb + i]);
      end
    end
    n_cmp++;
    if (done_cyc.size() - db != 1 || exp_done.size() != 1 || done_cyc[db] != exp_done[0]) begin
      n_err++;
      $display("FAIL bp_pkt_done: got %0d pulses, required 1", done_cyc.size() - db);
    end
  endtask

  task automatic test_zero_size();
    int pb = push_q.size();
    int rb = rx_data.size();
    int db = done_cyc.size();
    bus.credit_i = 1'b1;
    push(16'h0044); push(16'h0000); push(16'h0055); push(16'h0001); push(16'hC001);
    drain("zero_size");
    build_model(pb);
    build_done(rb);
    n_cmp++;
    if (rx_data.size() - rb != 5) begin
      n_err++;
      $display("FAIL zero_rx_count: got %0d, required 5", rx_data.size() - rb);
    end
    for (int i = 0; i < 5 && rb + i < rx_data.size(); i++) begin
      n_cmp++;
      if (rx_data[rb + i] !== push_q[pb + i]) begin
        n_err++;
        $display("FAIL zero_flit%0d: got %h, required %h", i, rx_data[rb + i], push_q[pb + i]);
      end
    end
    n_cmp++;
    if (done_cyc.size() - db != exp_done.size()) begin
      n_err++;
      $display("FAIL zero_done_count: got %0d, required %0d", done_cyc.size() - db, exp_done.size());
    end
    for (int i = 0; i < exp_done.size() && db + i < done_cyc.size(); i++) begin
      n_cmp++;
      if (done_cyc[db + i] != exp_done[i]) begin
        n_err++;
        $display("FAIL zero_done%0d: got cycle %0d, required %0d", i, done_cyc[db + i], exp_done[i]);
      end
    end
  endtask

  task automatic test_underflow();
    int pb = push_q.size();
    int rb = rx_data.size();
    int db = done_cyc.size();
    bus.credit_i = 1'b1;
    push(16'h0066); push(16'h0002);
    drain("underflow_a");
    n_cmp++;
    if (bus.tx !== 1'b0 || bus.sending !== 1'b1) begin
      n_err++;
      $display("FAIL uf_midpacket: tx=%b sending=%b, required 0 1", bus.tx, bus.sending);
    end
    repeat (3) tick();
    push(16'hB001); push(16'hB002);
    drain("underflow_b");
    build_model(pb);
    build_done(rb);
    n_cmp++;
    if (rx_data.size() - rb != 4) begin
      n_err++;
      $display("FAIL uf_rx_count: got %0d, required 4", rx_data.size() - rb);
    end
    for (int i = 0; i < 4 && rb + i < rx_data.size(); i++) begin
      n_cmp++;
      if (rx_data[rb + i] !== push_q[pb + i]) begin
        n_err++;
        $display("FAIL uf_flit%0d: got %h, required %h", i, rx_data[rb + i], push_q[pb + i]);
      end
    end
    n_cmp++;
    if (done_cyc.size() - db != 1 || exp_done.size() != 1 || done_cyc[db] != exp_done[0]) begin
      n_err++;
      $display("FAIL uf_pkt_done: got %0d pulses, required 1 after 0xB002", done_cyc.size() - db);
    end
    n_cmp++;
    if (bus.sending !== 1'b0) begin
      n_err++;
      $display("FAIL uf_sending_end: got %b, required 0", bus.sending);
    end
  endtask

  task automatic test_back_to_back();
    int pb = push_q.size();
    int rb = rx_data.size();
    int db = done_cyc.size();
    bus.credit_i = 1'b1;
    push(16'h0077); push(16'h0001); push(16'hD001);
    push(16'h0088); push(16'h0001); push(16'hD002);
    drain("back_to_back");
    build_model(pb);
    build_done(rb);
    n_cmp++;
    if (rx_data.size() - rb != 6 || rx_cyc[rb + 5] - rx_cyc[rb] != 5) begin
      n_err++;
      $display("FAIL b2b_gapless: got %0d transfers, required 6 in consecutive cycles",
               rx_data.size() - rb);
    end
    for (int i = 0; i < 6 && rb + i < rx_data.size(); i++) begin
      n_cmp++;
      if (rx_data[rb + i] !== push_q[pb + i]) begin
        n_err++;
        $display("FAIL b2b_flit%0d: got %h, required %h", i, rx_data[rb + i], push_q[pb + i]);
      end
    end
    n_cmp++;
    if (done_cyc.size() - db != 2 || exp_done.size() != 2 ||
        done_cyc[db] != exp_done[0] || done_cyc[db + 1] != exp_done[1]) begin
      n_err++;
      $display("FAIL b2b_pkt_done: got %0d pulses, required 2 at model cycles", done_cyc.size() - db);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] gen[$];
    int pb = push_q.size();
    int rb = rx_data.size();
    int db = done_cyc.size();
    int gi = 0;
    int k = 0;
    int n;
    for (int p = 0; p < 40; p++) begin
      n = $urandom_range(0, 5);
      gen.push_back(W'($urandom));
      gen.push_back(W'(n));
      for (int j = 0; j < n; j++) gen.push_back(W'($urandom));
    end
    while (gi < gen.size() && k < 5000) begin
      tick();
      k++;
      bus.credit_i = ($urandom_range(0, 3) != 0);
      if (push_q.size() - rd_ptr < D - 1 && $urandom_range(0, 3) != 0) begin
        push(gen[gi]);
        gi++;
      end
    end
    bus.credit_i = 1'b1;
    drain("random");
    build_model(pb);
    build_done(rb);
    n_cmp++;
    if (rx_data.size() - rb != gen.size()) begin
      n_err++;
      $display("FAIL rand_rx_count: got %0d, required %0d", rx_data.size() - rb, gen.size());
    end
    for (int i = 0; i < gen.size() && rb + i < rx_data.size(); i++) begin
      n_cmp++;
      if (rx_data[rb + i] !== gen[i]) begin
        n_err++;
        $display("FAIL rand_flit%0d: got %h, required %h", i, rx_data[rb + i], gen[i]);
      end
    end
    n_cmp++;
    if (done_cyc.size() - db != 40 || exp_done.size() != 40) begin
      n_err++;
      $display("FAIL rand_done_count: got %0d, required 40", done_cyc.size() - db);
    end
    for (int i = 0; i < exp_done.size() && db + i < done_cyc.size(); i++) begin
      n_cmp++;
      if (done_cyc[db + i] != exp_done[i]) begin
        n_err++;
        $display("FAIL rand_done%0d: got cycle %0d, required %0d", i, done_cyc[db + i], exp_done[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_zero_size();
    test_underflow();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
